// File: rtl/scl_timing_gen.sv
// rtl/scl_timing_gen.sv - I2C SCL quarter-period timing generator; optional clock stretching under `SCL_STRETCH_EN
module scl_timing_gen #(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [BITS_W-1:0] nbits,
  input  logic              scl_in,
  output logic              cmd_ready,
  output logic              scl_o,
  output logic              sda_chg,
  output logic              sda_smp,
  output logic              start_cond,
  output logic              stop_cond,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [BITS_W-1:0] bit_idx,
  output logic              stretch
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_RSTART, S_STOP, S_HOLD
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_DATA  = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;

  state_t            state_q, state_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  lim_q, lim_d;
  logic [BITS_W-1:0] bit_q, bit_d;
  logic [BITS_W-1:0] nbits_q, nbits_d;
  logic [DIV_W-1:0]  lim_new;
  logic              enter;
  logic              stall;
  logic              busy_d, scl_d, stretch_d, at_end, fin_pos;
  logic              err_d, done_d, chg_d, smp_d, start_d, stop_d;
  logic              scl_o_q, sda_chg_q, sda_smp_q, start_q, stop_q, done_q, err_q;

  // Index of the final quarter of one pass through a command (one bit for DATA)
  function automatic logic [1:0] last_qtr_of(state_t s);
    return (s == S_START || s == S_STOP) ? 2'd2 : 2'd3;
  endfunction

`ifdef SCL_STRETCH_EN
  logic stretch_q;
  assign stall   = stretch_q;
  assign stretch = stretch_q;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall         = 1'b0;
  assign stretch       = 1'b0;
`endif

  // Command acceptance, quarter/bit sequencing and next-cycle output decode
  always_comb begin
    lim_new = (div == '0) ? DIV_W'(1) : div;
    state_d = state_q;
    qtr_d   = qtr_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    enter   = 1'b0;
    err_d   = 1'b0;

    if (state_q == S_IDLE || state_q == S_HOLD) begin
      if (cmd_valid) begin
        case (cmd)
          CMD_START: state_d = (state_q == S_IDLE) ? S_START : S_RSTART;
          CMD_DATA: begin
            if (state_q == S_IDLE || nbits == '0) err_d = 1'b1;
            else begin
              state_d = S_DATA;
              nbits_d = nbits;
            end
          end
          CMD_STOP: begin
            if (state_q == S_IDLE) err_d = 1'b1;
            else state_d = S_STOP;
          end
          default: begin
            if (state_q == S_IDLE) err_d = 1'b1;
            else state_d = S_RSTART;
          end
        endcase
        if (!err_d) begin
          enter = 1'b1;
          qtr_d = 2'd0;
          cnt_d = '0;
          lim_d = lim_new;
          bit_d = '0;
        end
      end
    end else if (!stall) begin
      if (cnt_q != lim_q) begin
        cnt_d = cnt_q + DIV_W'(1);
      end else if (qtr_q != last_qtr_of(state_q)) begin
        qtr_d = qtr_q + 2'd1;
        cnt_d = '0;
        lim_d = lim_new;
        enter = 1'b1;
      end else if (state_q == S_DATA && bit_q != nbits_q - BITS_W'(1)) begin
        bit_d = bit_q + BITS_W'(1);
        qtr_d = 2'd0;
        cnt_d = '0;
        lim_d = lim_new;
        enter = 1'b1;
      end else begin
        state_d = (state_q == S_STOP) ? S_IDLE : S_HOLD;
        qtr_d   = 2'd0;
        cnt_d   = '0;
        bit_d   = '0;
      end
    end

    busy_d = !(state_d == S_IDLE || state_d == S_HOLD);
    case (state_d)
      S_START:  scl_d = (qtr_d < 2'd2);
      S_RSTART: scl_d = (qtr_d == 2'd1 || qtr_d == 2'd2);
      S_STOP:   scl_d = (qtr_d != 2'd0);
      S_DATA:   scl_d = qtr_d[1];
      S_HOLD:   scl_d = 1'b0;
      default:  scl_d = 1'b1;
    endcase

`ifdef SCL_STRETCH_EN
    stretch_d = busy_d && scl_d && !scl_in;
`else
    stretch_d = 1'b0;
`endif

    // A quarter's last cycle is only known once the next cycle is not a stretch cycle
    at_end  = busy_d && (cnt_d == lim_d) && !stretch_d;
    fin_pos = at_end && (qtr_d == last_qtr_of(state_d)) &&
              (state_d != S_DATA || bit_d == nbits_d - BITS_W'(1));
    done_d  = fin_pos;
    start_d = at_end && ((state_d == S_START  && qtr_d == 2'd1) ||
                         (state_d == S_RSTART && qtr_d == 2'd2));
    stop_d  = at_end && state_d == S_STOP && qtr_d == 2'd1;
    chg_d   = enter && qtr_d == 2'd0 &&
              (state_d == S_DATA || state_d == S_RSTART || state_d == S_STOP);
    smp_d   = enter && state_d == S_DATA && qtr_d == 2'd3;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qtr_q     <= 2'd0;
      cnt_q     <= '0;
      lim_q     <= '0;
      bit_q     <= '0;
      nbits_q   <= '0;
      scl_o_q   <= 1'b1;
      sda_chg_q <= 1'b0;
      sda_smp_q <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SCL_STRETCH_EN
      stretch_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      bit_q     <= bit_d;
      nbits_q   <= nbits_d;
      scl_o_q   <= scl_d;
      sda_chg_q <= chg_d;
      sda_smp_q <= smp_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef SCL_STRETCH_EN
      stretch_q <= stretch_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy       = !cmd_ready;
  assign scl_o      = scl_o_q;
  assign sda_chg    = sda_chg_q;
  assign sda_smp    = sda_smp_q;
  assign start_cond = start_q;
  assign stop_cond  = stop_q;
  assign done       = done_q;
  assign err        = err_q;
  assign bit_idx    = bit_q;

endmodule

// File: tb/tb_scl_timing_gen.sv
// tb/tb_scl_timing_gen.sv - randomized self-checking bench for scl_timing_gen against a quarter-level bus model
module tb_scl_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] div;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [3:0] nbits;
  logic       scl_in;
  logic       cmd_ready, scl_o, sda_chg, sda_smp, start_cond, stop_cond;
  logic       done, err, busy, stretch;
  logic [3:0] bit_idx;

  scl_timing_gen #(.DIV_W(8), .BITS_W(4)) dut (
    .clk(clk), .rst(rst), .div(div), .cmd_valid(cmd_valid), .cmd(cmd),
    .nbits(nbits), .scl_in(scl_in), .cmd_ready(cmd_ready), .scl_o(scl_o),
    .sda_chg(sda_chg), .sda_smp(sda_smp), .start_cond(start_cond),
    .stop_cond(stop_cond), .done(done), .err(err), .busy(busy),
    .bit_idx(bit_idx), .stretch(stretch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, ready, scl, chg, smp, sc, pc, dn, er, st;
    logic [3:0] bidx;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   bus_idle = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic rec_t observe();
    return {busy, cmd_ready, scl_o, sda_chg, sda_smp, start_cond, stop_cond,
            done, err, stretch, bit_idx};
  endfunction

  function automatic rec_t rest(input bit idle);
    rec_t r = '0;
    r.ready = 1'b1;
    r.scl   = idle;
    return r;
  endfunction

  task automatic push_quarter(input int len, input bit lvl, input bit chg, input bit smp,
                              input bit sc, input bit pc, input int b);
    for (int i = 0; i < len; i++) begin
      rec_t r = '0;
      r.busy = 1'b1;
      r.scl  = lvl;
      r.bidx = 4'(b);
      r.chg  = chg && (i == 0);
      r.smp  = smp && (i == 0);
      r.sc   = sc && (i == len - 1);
      r.pc   = pc && (i == len - 1);
      exp_q.push_back(r);
    end
  endtask

  // Issue one command, compare every cycle against the model trace, then the resting cycle.
  // abort_at: cycle in which rst is raised. stall_at: first stretched cycle (scl_in low 10 cycles before it).
  task automatic run_cmd(input logic [1:0] c, input int d, input int nb,
                         input int abort_at, input int stall_at);
    int   len;
    bit   legal;
    bit   next_idle;
    rec_t r;
    len       = ((d == 0) ? 1 : d) + 1;
    legal     = 1'b1;
    next_idle = bus_idle;
    exp_q.delete();
    case (c)
      2'b00: begin
        if (bus_idle) begin
          push_quarter(len, 1, 0, 0, 0, 0, 0);
          push_quarter(len, 1, 0, 0, 1, 0, 0);
          push_quarter(len, 0, 0, 0, 0, 0, 0);
        end else begin
          push_quarter(len, 0, 1, 0, 0, 0, 0);
          push_quarter(len, 1, 0, 0, 0, 0, 0);
          push_quarter(len, 1, 0, 0, 1, 0, 0);
          push_quarter(len, 0, 0, 0, 0, 0, 0);
        end
        next_idle = 1'b0;
      end
      2'b01: begin
        legal = !bus_idle && nb != 0;
        if (legal)
          for (int b = 0; b < nb; b++) begin
            push_quarter(len, 0, 1, 0, 0, 0, b);
            push_quarter(len, 0, 0, 0, 0, 0, b);
            push_quarter(len, 1, 0, 0, 0, 0, b);
            push_quarter(len, 1, 0, 1, 0, 0, b);
          end
      end
      2'b10: begin
        legal = !bus_idle;
        if (legal) begin
          push_quarter(len, 0, 1, 0, 0, 0, 0);
          push_quarter(len, 1, 0, 0, 0, 1, 0);
          push_quarter(len, 1, 0, 0, 0, 0, 0);
          next_idle = 1'b1;
        end
      end
      default: begin
        legal = !bus_idle;
        if (legal) begin
          push_quarter(len, 0, 1, 0, 0, 0, 0);
          push_quarter(len, 1, 0, 0, 0, 0, 0);
          push_quarter(len, 1, 0, 0, 1, 0, 0);
          push_quarter(len, 0, 0, 0, 0, 0, 0);
        end
      end
    endcase
    if (!legal) begin
      r    = rest(bus_idle);
      r.er = 1'b1;
      exp_q.push_back(r);
    end else begin
      exp_q[exp_q.size() - 1].dn = 1'b1;
    end
    if (stall_at > 0) begin
      r    = exp_q[stall_at - 1];
      r.st = 1'b1;
      repeat (10) exp_q.insert(stall_at - 1, r);
    end

    cmd_valid = 1'b1;
    cmd       = c;
    div       = 8'(d);
    nbits     = 4'(nb);
    @(posedge clk); #1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      check($sformatf("cmd%0d_cyc%0d", c, k), 32'(observe()), 32'(exp_q[k-1]));
      if (exp_q[k-1].busy) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd       = 2'($urandom);
        nbits     = 4'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      scl_in = !(stall_at > 0 && k >= stall_at - 1 && k <= stall_at + 8);
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        bus_idle  = 1'b1;
        check("abort_rst", 32'(observe()), 32'(rest(1'b1)));
        return;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    scl_in    = 1'b1;
    bus_idle  = next_idle;
    check($sformatf("cmd%0d_rest", c), 32'(observe()), 32'(rest(bus_idle)));
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    div       = 8'd3;
    nbits     = 4'd1;
    scl_in    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'(observe()), 32'(rest(1'b1)));
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("reset_release", 32'(observe()), 32'(rest(1'b1)));

    run_cmd(2'b10, 3, 0, 0, 0);   // STOP in IDLE -> err
    run_cmd(2'b00, 3, 0, 0, 0);   // START div=3
    run_cmd(2'b01, 3, 0, 0, 0);   // DATA nbits=0 -> err
    run_cmd(2'b01, 3, 8, 0, 0);   // DATA 8 bits
    run_cmd(2'b01, 3, 8, 54, 0);  // reset during bit 3
    run_cmd(2'b00, 3, 0, 0, 0);   // START after reset
    run_cmd(2'b11, 1, 0, 0, 0);   // RSTART div=1
    run_cmd(2'b10, 1, 0, 0, 0);   // STOP div=1
    run_cmd(2'b00, 0, 0, 0, 0);   // START div=0 behaves as div=1
    run_cmd(2'b00, 2, 0, 0, 0);   // START in HOLD runs as RSTART
    run_cmd(2'b01, 1, 15, 0, 0);  // DATA max bit count
    run_cmd(2'b10, 2, 0, 0, 0);

    for (int i = 0; i < 40; i++)
      run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 5), 0, 0);

`ifdef SCL_STRETCH_EN
    if (bus_idle) run_cmd(2'b00, 3, 0, 0, 0);
    run_cmd(2'b01, 3, 2, 0, 10);  // scl_in low 10 cycles inside Q2 of bit 0
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scl_timing_gen.md
SCL_TIMING_GEN -- requirements
Module: scl_timing_gen

Interface
REQ-001 Parameter DIV_W, default 8, width of the quarter-period divider input.
REQ-002 Parameter BITS_W, default 4, width of the bit-count input and bit index output.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 div  in  DIV_W  quarter-period length minus one, in clk cycles; 0 treated as 1.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd  in  2  00 START, 01 DATA, 10 STOP, 11 RSTART.
REQ-008 nbits  in  BITS_W  bit count for DATA, sampled on acceptance.
REQ-009 scl_in  in  1  sensed bus SCL level.
REQ-010 cmd_ready  out  1  high in IDLE and HOLD only.
REQ-011 scl_o  out  1  1 = release SCL high, 0 = drive low; registered.
REQ-012 sda_chg, sda_smp, start_cond, stop_cond  out  1 each  single-cycle strobes.
REQ-013 done, err  out  1 each  single-cycle command-complete and illegal-command strobes.
REQ-014 busy  out  1  high in any state other than IDLE and HOLD.
REQ-015 bit_idx  out  BITS_W  index of the current DATA bit, 0-based.
REQ-016 stretch  out  1  high while the SCL low-hold by a slave is extending the current quarter.

Function
REQ-017 A quarter SHALL last max(div,1)+1 cycles; the quarter counter restarts at 0 at the start of every quarter.
REQ-018 States SHALL be IDLE, START, DATA, RSTART, STOP, HOLD; a command is accepted when cmd_valid and cmd_ready are both high, and the first quarter begins on the next cycle.
REQ-019 IDLE: scl_o=1; START moves to START; DATA, STOP or RSTART pulses err for 1 cycle and leaves the state unchanged.
REQ-020 HOLD: scl_o=0; DATA, STOP and RSTART are accepted; START is accepted and executed as RSTART.
REQ-021 START: 2 quarters with SCL high, start_cond on the last cycle of quarter 1, then 1 quarter low; done pulses on the last cycle; next state HOLD.
REQ-022 RSTART: 1 quarter low with sda_chg on its first cycle, 2 quarters high with start_cond on the last cycle of quarter 2, then 1 quarter low; done on the last cycle; next state HOLD.
REQ-023 DATA: per bit, Q0/Q1 low and Q2/Q3 high; sda_chg on the first cycle of Q0, sda_smp on the first cycle of Q3; bit_idx increments after Q3.
REQ-024 DATA with nbits=0 SHALL pulse err and stay in HOLD with no SCL activity.
REQ-025 DATA ends after nbits bits; done on the last cycle of the final Q3; the state returns to HOLD with scl_o=0 on the next cycle.
REQ-026 STOP: 1 quarter low with sda_chg on its first cycle, 1 quarter high with stop_cond on its last cycle, 1 bus-free quarter high; done on the last cycle; next state IDLE.
REQ-027 cmd_valid SHALL be ignored while busy; no command is queued.
REQ-028 div and nbits changes take effect only at the next quarter start or command acceptance respectively.
REQ-029 At most one of done or err SHALL pulse per accepted command.

Reset
REQ-030 rst SHALL force IDLE on the next edge: scl_o=1, cmd_ready=1, busy=0, bit_idx=0, stretch=0, all strobes=0, counters=0.
REQ-031 rst SHALL take effect mid-command with no done pulse, and SHALL override cmd_valid in the same cycle.

Configuration
REQ-032 Macro SCL_STRETCH_EN defined: in any quarter with scl_o=1, while scl_in=0 the quarter counter holds and stretch=1; counting resumes on the cycle after scl_in returns to 1.
REQ-033 Macro SCL_STRETCH_EN undefined: scl_in is ignored, stretch is tied to 0, and the scl_in port remains present.

Verification
REQ-034 rst, div=3, START in IDLE -> scl_o high 8 cycles, start_cond at cycle 8, low 4 cycles, done at cycle 12, state HOLD.
REQ-035 After START, DATA nbits=8, div=3 -> 8 bits of 16 cycles, 8 sda_chg and 8 sda_smp pulses, bit_idx 0..7, done at cycle 128.
REQ-036 STOP in IDLE and DATA nbits=0 in HOLD -> err pulse 1 cycle, no done, state unchanged, scl_o unchanged.
REQ-037 SCL_STRETCH_EN defined, div=3, DATA, scl_in held low 10 cycles in Q2 of bit 0 -> stretch high 10 cycles, bit lengthened to 26 cycles, sda_smp delayed 10 cycles.
REQ-038 rst asserted during bit 3 of DATA -> next cycle IDLE, scl_o=1, no done; a subsequent START completes normally.
REQ-039 HOLD, RSTART then STOP, div=1 -> RSTART 8 cycles with start_cond at cycle 6, STOP 6 cycles with stop_cond at cycle 4, final state IDLE.
